// File: rtl/mouse_cfg_sequencer_if.sv
// Configuration bus between a MouseCtl config sequencer and its requesters.
// The master side raises requests and warp targets; the slave side (the
// sequencer) drives the MouseCtl config value, strobes and status.
interface mouse_cfg_sequencer_if;
    logic        init_req;
    logic        recenter;
    logic        warp_req;
    logic [11:0] warp_x;
    logic [11:0] warp_y;
    logic [11:0] value;
    logic        setx;
    logic        sety;
    logic        setmax_x;
    logic        setmax_y;
    logic        busy;
    logic        done;

    modport master (
        output init_req, recenter, warp_req, warp_x, warp_y,
        input  value, setx, sety, setmax_x, setmax_y, busy, done
    );

    modport slave (
        input  init_req, recenter, warp_req, warp_x, warp_y,
        output value, setx, sety, setmax_x, setmax_y, busy, done
    );
endinterface

// File: rtl/mouse_cfg_sequencer.sv
// MouseCtl configuration sequencer.
// Writes setmax_x/setmax_y/setx/sety one strobe at a time, with a settle gap
// after every strobe. There are three requesters: full init, warp and recenter.
// Requests are held in sticky pending flags and are served in fixed priority.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | nothing running; arbitrate pending/incoming requests
// WR_MAXX   | one cycle: setmax_x strobe, value = MAX_X
// WR_MAXY   | one cycle: setmax_y strobe, value = MAX_Y
// WR_X      | one cycle: setx strobe, value = latched X
// WR_Y      | one cycle: sety strobe, value = latched Y
// GAP       | GAP_CYCLES settle cycles, then go to r_after_gap
// DONE      | one cycle: done pulse; arbitrate again for back-to-back work
module mouse_cfg_sequencer #(
    parameter int unsigned MAX_X      = 1279,
    parameter int unsigned MAX_Y      = 1023,
    parameter int unsigned INIT_X     = 640,
    parameter int unsigned INIT_Y     = 512,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned AUTO_INIT  = 1
) (
    input  logic clk,
    input  logic rst,
    mouse_cfg_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_MAXX = 3'd1,
        S_WR_MAXY = 3'd2,
        S_WR_X    = 3'd3,
        S_WR_Y    = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [11:0] C_MAX_X  = 12'(MAX_X);
    localparam logic [11:0] C_MAX_Y  = 12'(MAX_Y);
    localparam logic [11:0] C_INIT_X = 12'(INIT_X);
    localparam logic [11:0] C_INIT_Y = 12'(INIT_Y);
    localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] C_GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic C_AUTO = (AUTO_INIT != 0);

    state_t      r_state;
    state_t      r_after_gap;
    logic [CW-1:0] r_cnt;
    logic        r_pend_init;
    logic        r_pend_warp;
    logic        r_pend_rec;
    logic        r_auto_first;
    logic [11:0] r_warp_x;
    logic [11:0] r_warp_y;
    logic [11:0] r_val_x;
    logic [11:0] r_val_y;

    state_t      w_state_nxt;
    state_t      w_after_gap_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic        w_req_init;
    logic        w_req_warp;
    logic        w_req_rec;
    logic        w_start_init;
    logic        w_start_warp;
    logic        w_start_rec;
    logic [11:0] w_warp_x_src;
    logic [11:0] w_warp_y_src;
    logic [11:0] w_clamp_x;
    logic [11:0] w_clamp_y;
    logic [11:0] w_value;
    logic        w_setx;
    logic        w_sety;
    logic        w_setmax_x;
    logic        w_setmax_y;
    logic        w_busy;
    logic        w_done;

    // An incoming pulse counts as pending in the same cycle. This lets a
    // request seen in IDLE produce its first strobe on the next cycle.
    // r_auto_first is the power-up init request. It is live only during the
    // first cycle after reset release.
    assign w_req_init = r_pend_init | bus.init_req | r_auto_first;
    assign w_req_warp = r_pend_warp | bus.warp_req;
    assign w_req_rec  = r_pend_rec  | bus.recenter;

    // A warp that starts in the same cycle as its request uses the live inputs.
    assign w_warp_x_src = bus.warp_req ? bus.warp_x : r_warp_x;
    assign w_warp_y_src = bus.warp_req ? bus.warp_y : r_warp_y;
    assign w_clamp_x    = (w_warp_x_src > C_MAX_X) ? C_MAX_X : w_warp_x_src;
    assign w_clamp_y    = (w_warp_y_src > C_MAX_Y) ? C_MAX_Y : w_warp_y_src;

    // State register, gap return target and gap down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_after_gap <= S_IDLE;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_after_gap <= w_after_gap_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state logic, strobe/value decode and request arbitration
    always_comb begin
        w_state_nxt     = r_state;
        w_after_gap_nxt = r_after_gap;
        w_cnt_nxt       = r_cnt;
        w_start_init    = 1'b0;
        w_start_warp    = 1'b0;
        w_start_rec     = 1'b0;
        w_value         = 12'd0;
        w_setx          = 1'b0;
        w_sety          = 1'b0;
        w_setmax_x      = 1'b0;
        w_setmax_y      = 1'b0;
        w_busy          = (r_state != S_IDLE);
        w_done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_WR_MAXX: begin
                w_setmax_x = 1'b1;
                w_value    = C_MAX_X;
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_WR_MAXY;
                end else begin
                    w_state_nxt     = S_GAP;
                    w_after_gap_nxt = S_WR_MAXY;
                    w_cnt_nxt       = C_GAP_LOAD;
                end
            end
            S_WR_MAXY: begin
                w_setmax_y = 1'b1;
                w_value    = C_MAX_Y;
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_WR_X;
                end else begin
                    w_state_nxt     = S_GAP;
                    w_after_gap_nxt = S_WR_X;
                    w_cnt_nxt       = C_GAP_LOAD;
                end
            end
            S_WR_X: begin
                w_setx  = 1'b1;
                w_value = r_val_x;
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_WR_Y;
                end else begin
                    w_state_nxt     = S_GAP;
                    w_after_gap_nxt = S_WR_Y;
                    w_cnt_nxt       = C_GAP_LOAD;
                end
            end
            S_WR_Y: begin
                w_sety  = 1'b1;
                w_value = r_val_y;
                if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt     = S_GAP;
                    w_after_gap_nxt = S_DONE;
                    w_cnt_nxt       = C_GAP_LOAD;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = r_after_gap;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Arbitrate in DONE as well as IDLE. Queued work then follows the
        // done pulse with no idle cycle in between.
        if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            if (w_req_init) begin
                w_start_init = 1'b1;
                w_state_nxt  = S_WR_MAXX;
            end else if (w_req_warp) begin
                w_start_warp = 1'b1;
                w_state_nxt  = S_WR_X;
            end else if (w_req_rec) begin
                w_start_rec  = 1'b1;
                w_state_nxt  = S_WR_X;
            end
        end
    end

    // Sticky pending flags, warp target latch and per-sequence X/Y values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto_first <= C_AUTO;
            r_pend_init  <= 1'b0;
            r_pend_warp  <= 1'b0;
            r_pend_rec   <= 1'b0;
            r_warp_x     <= 12'd0;
            r_warp_y     <= 12'd0;
            r_val_x      <= 12'd0;
            r_val_y      <= 12'd0;
        end else begin
            r_auto_first <= 1'b0;
            r_pend_init  <= w_req_init & ~w_start_init;
            r_pend_warp  <= w_req_warp & ~w_start_warp;
            // A full init also writes the recenter coordinates, so it absorbs
            // any recenter that is already pending.
            r_pend_rec   <= w_req_rec & ~(w_start_rec | w_start_init);
            if (bus.warp_req) begin
                r_warp_x <= bus.warp_x;
                r_warp_y <= bus.warp_y;
            end
            if (w_start_init || w_start_rec) begin
                r_val_x <= C_INIT_X;
                r_val_y <= C_INIT_Y;
            end else if (w_start_warp) begin
                r_val_x <= w_clamp_x;
                r_val_y <= w_clamp_y;
            end
        end
    end

    assign bus.value    = w_value;
    assign bus.setx     = w_setx;
    assign bus.sety     = w_sety;
    assign bus.setmax_x = w_setmax_x;
    assign bus.setmax_y = w_setmax_y;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;

endmodule
